// File: rtl/ctrl_pipe_pkg.sv
// Shared definitions for the pipelined CPU control path: control bundle layout,
// register index width and the EX-stage forwarding select encodings.
package ctrl_pipe_pkg;

  localparam int CTRL_W = 8;
  localparam int REG_AW = 5;

  localparam int CTRL_REGWRITE = 7;
  localparam int CTRL_MEMTOREG = 6;
  localparam int CTRL_MEMREAD  = 5;
  localparam int CTRL_MEMWRITE = 4;
  localparam int CTRL_ALUSRC   = 3;
  localparam int CTRL_ALUOP_HI = 2;
  localparam int CTRL_ALUOP_LO = 1;
  localparam int CTRL_REGDST   = 0;

  localparam logic [1:0] FWD_REG   = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b10;
  localparam logic [1:0] FWD_MEMWB = 2'b01;

endpackage

// File: rtl/ctrl_pipe_hazard_unit.sv
// Combinational hazard logic: load-use stall, IF/ID flush on taken branch or
// jump, and EX-stage operand forwarding selects.
module hazard_unit
  import ctrl_pipe_pkg::*;
(
  input  logic              idex_memread,
  input  logic [REG_AW-1:0] idex_rs,
  input  logic [REG_AW-1:0] idex_rt,
  input  logic [REG_AW-1:0] ifid_rs,
  input  logic [REG_AW-1:0] ifid_rt,
  input  logic              branch,
  input  logic              jump,
  input  logic              eq,
  input  logic              exmem_regwrite,
  input  logic [REG_AW-1:0] exmem_wr,
  input  logic              memwb_regwrite,
  input  logic [REG_AW-1:0] memwb_wr,
  output logic              stall,
  output logic              flush,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b
);

  // EX/MEM is the younger producer, so it wins over MEM/WB; r0 never forwards.
  function automatic logic [1:0] fwd_sel(
    input logic [REG_AW-1:0] src,
    input logic              ex_rw,
    input logic [REG_AW-1:0] ex_wr,
    input logic              wb_rw,
    input logic [REG_AW-1:0] wb_wr
  );
    if (ex_rw && (ex_wr != '0) && (ex_wr == src))
      return FWD_EXMEM;
    else if (wb_rw && (wb_wr != '0) && (wb_wr == src))
      return FWD_MEMWB;
    else
      return FWD_REG;
  endfunction

  always_comb begin
    stall = idex_memread && (idex_rt != '0) &&
            ((idex_rt == ifid_rs) || (idex_rt == ifid_rt));
    // A stalled branch re-resolves next cycle, so it must not flush now.
    flush = !stall && ((branch && eq) || jump);
    fwd_a = fwd_sel(idex_rs, exmem_regwrite, exmem_wr, memwb_regwrite, memwb_wr);
    fwd_b = fwd_sel(idex_rt, exmem_regwrite, exmem_wr, memwb_regwrite, memwb_wr);
  end

endmodule

// File: rtl/ctrl_pipe.sv
// Carries the decoder's control bundle from ID through ID/EX, EX/MEM and MEM/WB,
// presenting each field in the stage that consumes it.
module ctrl_pipe
  import ctrl_pipe_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [CTRL_W-1:0] ConMux_i,
  input  logic              Branch_i,
  input  logic              Jump_i,
  input  logic              Eq_i,
  input  logic [REG_AW-1:0] IFID_rs_i,
  input  logic [REG_AW-1:0] IFID_rt_i,
  input  logic [REG_AW-1:0] IFID_rd_i,
  output logic              PCWrite_o,
  output logic              IFIDWrite_o,
  output logic              IFFlush_o,
  output logic              ALUSrc_o,
  output logic [1:0]        ALUOp_o,
  output logic              RegDst_o,
  output logic              MemRead_o,
  output logic              MemWrite_o,
  output logic              RegWrite_o,
  output logic              MemtoReg_o,
  output logic [REG_AW-1:0] WBReg_o,
  output logic [1:0]        ForwardA_o,
  output logic [1:0]        ForwardB_o
);

  logic [CTRL_W-1:0] idex_ctrl_p0;
  logic [REG_AW-1:0] idex_rs_p0, idex_rt_p0, idex_rd_p0;
  logic              exmem_regwrite_p1, exmem_memtoreg_p1;
  logic              exmem_memread_p1, exmem_memwrite_p1;
  logic [REG_AW-1:0] exmem_wr_p1;
  logic              memwb_regwrite_p2, memwb_memtoreg_p2;
  logic [REG_AW-1:0] memwb_wr_p2;
  logic [REG_AW-1:0] write_reg;
  logic              stall;

  hazard_unit u_hazard (
    .idex_memread   (idex_ctrl_p0[CTRL_MEMREAD]),
    .idex_rs        (idex_rs_p0),
    .idex_rt        (idex_rt_p0),
    .ifid_rs        (IFID_rs_i),
    .ifid_rt        (IFID_rt_i),
    .branch         (Branch_i),
    .jump           (Jump_i),
    .eq             (Eq_i),
    .exmem_regwrite (exmem_regwrite_p1),
    .exmem_wr       (exmem_wr_p1),
    .memwb_regwrite (memwb_regwrite_p2),
    .memwb_wr       (memwb_wr_p2),
    .stall          (stall),
    .flush          (IFFlush_o),
    .fwd_a          (ForwardA_o),
    .fwd_b          (ForwardB_o)
  );

  assign write_reg = idex_ctrl_p0[CTRL_REGDST] ? idex_rd_p0 : idex_rt_p0;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      idex_ctrl_p0      <= '0;
      idex_rs_p0        <= '0;
      idex_rt_p0        <= '0;
      idex_rd_p0        <= '0;
      exmem_regwrite_p1 <= 1'b0;
      exmem_memtoreg_p1 <= 1'b0;
      exmem_memread_p1  <= 1'b0;
      exmem_memwrite_p1 <= 1'b0;
      exmem_wr_p1       <= '0;
      memwb_regwrite_p2 <= 1'b0;
      memwb_memtoreg_p2 <= 1'b0;
      memwb_wr_p2       <= '0;
    end else begin
      // ID -> EX: a stall inserts a bubble, which also ends the stall next cycle
      idex_ctrl_p0      <= stall ? '0 : ConMux_i;
      idex_rs_p0        <= IFID_rs_i;
      idex_rt_p0        <= IFID_rt_i;
      idex_rd_p0        <= IFID_rd_i;
      // EX -> MEM
      exmem_regwrite_p1 <= idex_ctrl_p0[CTRL_REGWRITE];
      exmem_memtoreg_p1 <= idex_ctrl_p0[CTRL_MEMTOREG];
      exmem_memread_p1  <= idex_ctrl_p0[CTRL_MEMREAD];
      exmem_memwrite_p1 <= idex_ctrl_p0[CTRL_MEMWRITE];
      exmem_wr_p1       <= write_reg;
      // MEM -> WB
      memwb_regwrite_p2 <= exmem_regwrite_p1;
      memwb_memtoreg_p2 <= exmem_memtoreg_p1;
      memwb_wr_p2       <= exmem_wr_p1;
    end
  end

  assign PCWrite_o   = !stall;
  assign IFIDWrite_o = !stall;
  assign ALUSrc_o    = idex_ctrl_p0[CTRL_ALUSRC];
  assign ALUOp_o     = idex_ctrl_p0[CTRL_ALUOP_HI:CTRL_ALUOP_LO];
  assign RegDst_o    = idex_ctrl_p0[CTRL_REGDST];
  assign MemRead_o   = exmem_memread_p1;
  assign MemWrite_o  = exmem_memwrite_p1;
  assign RegWrite_o  = memwb_regwrite_p2;
  assign MemtoReg_o  = memwb_memtoreg_p2;
  assign WBReg_o     = memwb_wr_p2;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Directed self-checking bench for ctrl_pipe: reset, latency, load-use stall,
// forwarding priority, register-0 handling, and flush versus stall.
module tb_ctrl_pipe;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] con_mux;
  logic       branch, jump, eq;
  logic [4:0] rs, rt, rd;
  logic       pc_write, ifid_write, if_flush;
  logic       alu_src, reg_dst, mem_read, mem_write, reg_write, mem_to_reg;
  logic [1:0] alu_op, fwd_a, fwd_b;
  logic [4:0] wb_reg;

  int checks = 0;
  int errors = 0;

  ctrl_pipe dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .ConMux_i    (con_mux),
    .Branch_i    (branch),
    .Jump_i      (jump),
    .Eq_i        (eq),
    .IFID_rs_i   (rs),
    .IFID_rt_i   (rt),
    .IFID_rd_i   (rd),
    .PCWrite_o   (pc_write),
    .IFIDWrite_o (ifid_write),
    .IFFlush_o   (if_flush),
    .ALUSrc_o    (alu_src),
    .ALUOp_o     (alu_op),
    .RegDst_o    (reg_dst),
    .MemRead_o   (mem_read),
    .MemWrite_o  (mem_write),
    .RegWrite_o  (reg_write),
    .MemtoReg_o  (mem_to_reg),
    .WBReg_o     (wb_reg),
    .ForwardA_o  (fwd_a),
    .ForwardB_o  (fwd_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then let outputs settle before anyone looks.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    con_mux = 8'h00; branch = 1'b0; jump = 1'b0; eq = 1'b0;
    rs = 5'd0; rt = 5'd0; rd = 5'd0;
  endtask

  task automatic drain();
    idle_inputs();
    repeat (3) tick();
  endtask

  initial begin
    idle_inputs();
    rst = 1'b0;
    con_mux = 8'hFF;
    tick(); tick();
    check("rst_alusrc",   {7'd0, alu_src}, 8'd0);
    check("rst_aluop",    {6'd0, alu_op}, 8'd0);
    check("rst_memread",  {7'd0, mem_read}, 8'd0);
    check("rst_regwrite", {7'd0, reg_write}, 8'd0);
    check("rst_wbreg",    {3'd0, wb_reg}, 8'd0);
    check("rst_fwd",      {4'd0, fwd_a, fwd_b}, 8'd0);
    check("rst_pcwrite",  {6'd0, pc_write, ifid_write}, 8'h03);
    check("rst_flush",    {7'd0, if_flush}, 8'd0);

    // Release: 8'hFF with rd=0 walks through all three stages.
    rst = 1'b1;
    tick();
    check("ff_ex", {4'd0, alu_src, alu_op, reg_dst}, 8'h0F);
    con_mux = 8'h00;
    tick();
    check("ff_mem", {6'd0, mem_read, mem_write}, 8'h03);
    check("ff_mem_notyet_wb", {7'd0, reg_write}, 8'd0);
    check("ff_r0_nofwd", {4'd0, fwd_a, fwd_b}, 8'd0);
    tick();
    check("ff_wb", {6'd0, reg_write, mem_to_reg}, 8'h03);
    check("ff_wbreg_r0", {3'd0, wb_reg}, 8'd0);

    // Reset mid-stream discards everything in flight.
    drain();
    con_mux = 8'hFF; rd = 5'd6;
    tick();
    con_mux = 8'h00;
    tick();
    rst = 1'b0;
    tick();
    check("midrst_ex",  {4'd0, alu_src, alu_op, reg_dst}, 8'd0);
    check("midrst_mem", {6'd0, mem_read, mem_write}, 8'd0);
    rst = 1'b1;
    tick();
    check("midrst_wb", {3'd0, reg_write, mem_to_reg, wb_reg[2:0]}, 8'd0);

    // lw rt=9 propagation.
    drain();
    con_mux = 8'hE8; rt = 5'd9;
    tick();
    check("lw_ex", {4'd0, alu_src, alu_op, reg_dst}, 8'h08);
    idle_inputs();
    #1;
    check("lw_nostall", {6'd0, pc_write, ifid_write}, 8'h03);
    tick();
    check("lw_mem", {6'd0, mem_read, mem_write}, 8'h02);
    tick();
    check("lw_wb", {6'd0, reg_write, mem_to_reg}, 8'h03);
    check("lw_wbreg", {3'd0, wb_reg}, 8'd9);

    // Load-use: lw rt=8 in EX, add rs=8 rt=3 rd=4 in ID.
    drain();
    con_mux = 8'hE8; rt = 5'd8;
    tick();
    con_mux = 8'h81; rs = 5'd8; rt = 5'd3; rd = 5'd4;
    #1;
    check("lu_stall", {6'd0, pc_write, ifid_write}, 8'h00);
    tick();
    check("lu_bubble", {4'd0, alu_src, alu_op, reg_dst}, 8'h00);
    check("lu_release", {6'd0, pc_write, ifid_write}, 8'h03);
    tick();
    check("lu_fwd_a", {6'd0, fwd_a}, 8'h01);
    check("lu_fwd_b", {6'd0, fwd_b}, 8'h00);
    check("lu_add_ex", {7'd0, reg_dst}, 8'h01);

    // Forward priority: two adds writing r5, then consumer rs=rt=5.
    drain();
    con_mux = 8'h81; rs = 5'd1; rt = 5'd2; rd = 5'd5;
    tick(); tick();
    con_mux = 8'h00; rs = 5'd5; rt = 5'd5; rd = 5'd0;
    tick();
    check("prio_both", {4'd0, fwd_a, fwd_b}, 8'b0000_1010);
    tick();
    check("prio_wbonly", {4'd0, fwd_a, fwd_b}, 8'b0000_0101);

    // Same producers writing r0: never forwarded, but RegWrite still flows.
    drain();
    con_mux = 8'h81; rs = 5'd1; rt = 5'd2; rd = 5'd0;
    tick(); tick();
    con_mux = 8'h00; rs = 5'd0; rt = 5'd0;
    tick();
    check("r0_nofwd", {4'd0, fwd_a, fwd_b}, 8'd0);
    check("r0_regwrite", {2'd0, reg_write, wb_reg}, 8'b0010_0000);

    // Flush versus stall.
    drain();
    branch = 1'b1; eq = 1'b1;
    #1;
    check("br_flush", {7'd0, if_flush}, 8'h01);
    branch = 1'b0; eq = 1'b0; con_mux = 8'hE8; rt = 5'd7;
    tick();
    branch = 1'b1; eq = 1'b1; con_mux = 8'h00; rs = 5'd1; rt = 5'd7;
    #1;
    check("br_stall_noflush", {7'd0, if_flush}, 8'h00);
    check("br_stall_pc", {7'd0, pc_write}, 8'h00);
    tick();
    check("br_reflush", {7'd0, if_flush}, 8'h01);
    check("br_pc_free", {7'd0, pc_write}, 8'h01);

    // Jump: one-cycle flush, all-zero bundle flows harmlessly.
    drain();
    jump = 1'b1;
    #1;
    check("j_flush", {7'd0, if_flush}, 8'h01);
    tick();
    jump = 1'b0;
    #1;
    check("j_flush_end", {7'd0, if_flush}, 8'h00);
    check("j_ex", {4'd0, alu_src, alu_op, reg_dst}, 8'h00);
    tick();
    check("j_mem", {6'd0, mem_read, mem_write}, 8'h00);
    tick();
    check("j_wb", {7'd0, reg_write}, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
